// File: rtl/sa_out_scale_serializer_pkg.sv
// Shared constants, state encoding and helpers for the systolic-array output scaler/serializer.
package sa_out_scale_serializer_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned FRAC  = 13;
    localparam int unsigned COLS  = 64;
    localparam int unsigned ROW_W = COLS * DW;

    localparam logic [DW-1:0] ONE     = 16'h2000;
    localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DW-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSend = 2'd2
    } state_e;

    // Bit offset of row r inside a packed result block.
    function automatic int unsigned row_lsb(input int unsigned r);
        return r * ROW_W;
    endfunction

endpackage

// File: rtl/sa_out_scale_serializer_fx_mul_rnd_sat.sv
// One combinational Q2.13 lane: signed multiply, round half up, saturate to DW bits.
module fx_mul_rnd_sat
    import sa_out_scale_serializer_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] scale,
    output logic [DW-1:0] y
);

    localparam int unsigned PW = 2 * DW;
    localparam logic signed [PW-1:0] RND  = PW'(2 ** (FRAC - 1));
    localparam logic signed [PW-1:0] QMAX = {{DW{1'b0}}, SAT_MAX};
    localparam logic signed [PW-1:0] QMIN = {{DW{1'b1}}, SAT_MIN};

    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;

    assign p = PW'($signed(a)) * PW'($signed(scale));
    // Adding half an output LSB before the arithmetic shift rounds ties toward +inf.
    assign q = (p + RND) >>> FRAC;

    always_comb begin
        y = q[DW-1:0];
        if (q > QMAX) begin
            y = SAT_MAX;
        end else if (q < QMIN) begin
            y = SAT_MIN;
        end
    end

endmodule

// File: rtl/sa_out_scale_serializer.sv
// Captures an X_R x COLS result block, scales each element and streams it out one row per
// valid/ready handshake.
module sa_out_scale_serializer
    import sa_out_scale_serializer_pkg::*;
#(
    parameter int unsigned X_R = 2,
    localparam int unsigned IW = (X_R > 1) ? $clog2(X_R) : 1
) (
    input  logic                  I_CLK,
    input  logic                  I_RST_N,
    input  logic                  I_SA_VLD,
    input  logic [X_R*ROW_W-1:0]  I_SA_OUT,
    input  logic [DW-1:0]         I_SCALE,
    input  logic                  I_ROW_RDY,
    output logic                  O_ROW_VLD,
    output logic [ROW_W-1:0]      O_ROW_DATA,
    output logic [IW-1:0]         O_ROW_IDX,
    output logic                  O_ROW_LAST,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic                  O_ERR_OVF
);

    localparam logic [IW-1:0] LAST_ROW = IW'(X_R - 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] buf_q [X_R];
    logic [ROW_W-1:0] buf_d [X_R];
    logic [DW-1:0]    scale_q, scale_d;
    logic [IW-1:0]    row_q, row_d;
    logic [ROW_W-1:0] data_q, data_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             last_q, last_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [ROW_W-1:0] sel_row;
    logic [ROW_W-1:0] scaled_row;

    assign sel_row = buf_q[row_q];

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        fx_mul_rnd_sat u_lane (
            .a     (sel_row[c*DW +: DW]),
            .scale (scale_q),
            .y     (scaled_row[c*DW +: DW])
        );
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= StIdle;
            for (int r = 0; r < X_R; r++) begin
                buf_q[r] <= '0;
            end
            scale_q <= '0;
            row_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            scale_q <= scale_d;
            row_q   <= row_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        scale_d = scale_q;
        row_d   = row_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        // A strobe outside IDLE is dropped but remembered until reset.
        err_d   = err_q | (I_SA_VLD && (state_q != StIdle));

        case (state_q)
            StIdle: begin
                if (I_SA_VLD) begin
                    for (int r = 0; r < X_R; r++) begin
                        buf_d[r] = I_SA_OUT[row_lsb(r) +: ROW_W];
                    end
                    scale_d = I_SCALE;
                    row_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                data_d  = scaled_row;
                idx_d   = row_q;
                last_d  = (row_q == LAST_ROW);
                vld_d   = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (I_ROW_RDY) begin
                    vld_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d   = row_q + IW'(1);
                        state_d = StCalc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign O_ROW_VLD  = vld_q;
    assign O_ROW_DATA = data_q;
    assign O_ROW_IDX  = idx_q;
    assign O_ROW_LAST = last_q;
    assign O_BUSY     = (state_q != StIdle);
    assign O_DONE     = done_q;
    assign O_ERR_OVF  = err_q;

endmodule

// File: tb/tb_sa_out_scale_serializer.sv
// Directed bench for sa_out_scale_serializer: lane arithmetic table plus handshake,
// overrun and reset sequences with X_R = 2.
module tb_sa_out_scale_serializer;

    localparam int X_R  = 2;
    localparam int COLS = 64;
    localparam int DW   = 16;
    localparam int RW   = COLS * DW;
    localparam int BW   = X_R * RW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sa_vld = 1'b0;
    logic [BW-1:0] sa_out = '0;
    logic [DW-1:0] scale = '0;
    logic          rdy = 1'b0;
    logic          row_vld;
    logic [RW-1:0] row_data;
    logic          row_idx;
    logic          row_last;
    logic          busy;
    logic          done;
    logic          err_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    sa_out_scale_serializer #(.X_R(X_R)) dut (
        .I_CLK      (clk),
        .I_RST_N    (rst_n),
        .I_SA_VLD   (sa_vld),
        .I_SA_OUT   (sa_out),
        .I_SCALE    (scale),
        .I_ROW_RDY  (rdy),
        .O_ROW_VLD  (row_vld),
        .O_ROW_DATA (row_data),
        .O_ROW_IDX  (row_idx),
        .O_ROW_LAST (row_last),
        .O_BUSY     (busy),
        .O_DONE     (done),
        .O_ERR_OVF  (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] s;
        logic [DW-1:0] e;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [RW-1:0] splat(input logic [DW-1:0] v);
        logic [RW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [RW-1:0] col0(input logic [DW-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        r[DW-1:0] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [RW-1:0] act,
                             input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int c = 0; c < COLS; c++) begin
                if (act[c*DW +: DW] !== exp[c*DW +: DW]) begin
                    $display("FAIL %s: col %0d got %h want %h", name, c,
                             act[c*DW +: DW], exp[c*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    // Called at a negedge; holds the strobe for exactly one rising edge.
    task automatic send_block(input logic [BW-1:0] b, input logic [DW-1:0] s);
        sa_out = b;
        scale  = s;
        sa_vld = 1'b1;
        @(negedge clk);
        sa_vld = 1'b0;
    endtask

    task automatic wait_row(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (row_vld) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout got row_vld=0 want 1", name);
        end
    endtask

    task automatic get_row(input string name, input logic [RW-1:0] exp, input logic idx,
                           input logic last);
        bit ok;
        wait_row(name, ok);
        if (ok) begin
            check_row({name, " data"}, row_data, exp);
            check({name, " idx"}, 64'(row_idx), 64'(idx));
            check({name, " last"}, 64'(row_last), 64'(last));
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout got done=0 want 1", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " vld"}, 64'(row_vld), 64'd0);
        check_row({name, " data"}, row_data, '0);
        check({name, " idx"}, 64'(row_idx), 64'd0);
        check({name, " last"}, 64'(row_last), 64'd0);
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " done"}, 64'(done), 64'd0);
        check({name, " err"}, 64'(err_ovf), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RW-1:0] r1;
        logic [RW-1:0] held;
        logic [BW-1:0] blk_a;
        logic [BW-1:0] blk_b;
        bit ok;

        vecs[0]  = '{16'h4000, 16'h1000, 16'h2000};
        vecs[1]  = '{16'h0001, 16'h1000, 16'h0001};
        vecs[2]  = '{16'hFFFF, 16'h1000, 16'h0000};
        vecs[3]  = '{16'hE000, 16'h1000, 16'hF000};
        vecs[4]  = '{16'h0003, 16'h1000, 16'h0002};
        vecs[5]  = '{16'hFFFD, 16'h1000, 16'hFFFF};
        vecs[6]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[7]  = '{16'h8000, 16'h7FFF, 16'h8000};
        vecs[8]  = '{16'h8000, 16'h8000, 16'h7FFF};
        vecs[9]  = '{16'hC000, 16'hC000, 16'h7FFF};
        vecs[10] = '{16'h2000, 16'hE000, 16'hE000};
        vecs[11] = '{16'h1234, 16'h2000, 16'h1234};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through with exact cycle timing
        rdy = 1'b1;
        r1 = splat(16'h2000);
        r1[DW-1:0] = 16'h3000;
        r1[2*DW-1:DW] = 16'h4000;
        send_block({r1, splat(16'h1000)}, 16'h2000);
        check("pt t+1 vld", 64'(row_vld), 64'd0);
        check("pt t+1 busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("pt t+2 vld", 64'(row_vld), 64'd1);
        check_row("pt t+2 data", row_data, splat(16'h1000));
        check("pt t+2 idx", 64'(row_idx), 64'd0);
        check("pt t+2 last", 64'(row_last), 64'd0);
        @(negedge clk);
        check("pt t+3 vld", 64'(row_vld), 64'd0);
        @(negedge clk);
        check("pt t+4 vld", 64'(row_vld), 64'd1);
        check_row("pt t+4 data", row_data, r1);
        check("pt t+4 idx", 64'(row_idx), 64'd1);
        check("pt t+4 last", 64'(row_last), 64'd1);
        @(negedge clk);
        check("pt t+5 done", 64'(done), 64'd1);
        check("pt t+5 vld", 64'(row_vld), 64'd0);
        check("pt t+5 last", 64'(row_last), 64'd0);
        check("pt t+5 busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("pt t+6 done", 64'(done), 64'd0);

        // Lane arithmetic table: row0 fully populated, row1 only column 0
        for (int i = 0; i < 12; i++) begin
            send_block({col0(vecs[i].a), splat(vecs[i].a)}, vecs[i].s);
            get_row($sformatf("vec%0d row0", i), splat(vecs[i].e), 1'b0, 1'b0);
            get_row($sformatf("vec%0d row1", i), col0(vecs[i].e), 1'b1, 1'b1);
            wait_done($sformatf("vec%0d done", i));
            @(negedge clk);
        end

        // Backpressure on row0
        rdy = 1'b0;
        send_block({splat(16'h0400), splat(16'h0800)}, 16'h1000);
        wait_row("bp row0", ok);
        held = row_data;
        check_row("bp row0 data", held, splat(16'h0400));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d vld", i), 64'(row_vld), 64'd1);
            check_row($sformatf("bp hold%0d data", i), row_data, held);
            check($sformatf("bp hold%0d idx", i), 64'(row_idx), 64'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        check("bp h+1 vld", 64'(row_vld), 64'd0);
        @(negedge clk);
        check("bp h+2 vld", 64'(row_vld), 64'd1);
        check_row("bp h+2 data", row_data, splat(16'h0200));
        check("bp h+2 idx", 64'(row_idx), 64'd1);
        check("bp h+2 last", 64'(row_last), 64'd1);
        @(negedge clk);
        wait_done("bp done");
        @(negedge clk);

        // Overrun during SEND, then a new block accepted in the DONE cycle
        rdy = 1'b0;
        blk_a = {splat(16'h0111), splat(16'h0222)};
        blk_b = {splat(16'h0600), splat(16'h0A00)};
        send_block(blk_a, 16'h2000);
        wait_row("ovf A row0", ok);
        check("ovf before", 64'(err_ovf), 64'd0);
        send_block(blk_b, 16'h1000);
        check("ovf set", 64'(err_ovf), 64'd1);
        check_row("ovf held data", row_data, splat(16'h0222));
        rdy = 1'b1;
        get_row("ovf A row0", splat(16'h0222), 1'b0, 1'b0);
        get_row("ovf A row1", splat(16'h0111), 1'b1, 1'b1);
        wait_done("ovf A done");
        send_block(blk_b, 16'h1000);
        get_row("ovf B row0", splat(16'h0500), 1'b0, 1'b0);
        get_row("ovf B row1", splat(16'h0300), 1'b1, 1'b1);
        wait_done("ovf B done");
        check("ovf sticky", 64'(err_ovf), 64'd1);
        @(negedge clk);

        // Asynchronous reset during SEND of row0
        rdy = 1'b0;
        send_block(blk_a, 16'h2000);
        wait_row("rst row0", ok);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst post busy", 64'(busy), 64'd0);
        check("rst post vld", 64'(row_vld), 64'd0);
        rdy = 1'b1;
        send_block(blk_b, 16'h1000);
        get_row("rst fresh row0", splat(16'h0500), 1'b0, 1'b0);
        get_row("rst fresh row1", splat(16'h0300), 1'b1, 1'b1);
        wait_done("rst fresh done");
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
